risc_sequencer: RTL and testbench



---
 rtl/risc_pkg.sv | 22 ++
 rtl/risc_phase_counter.sv | 15 +
 rtl/risc_sequencer.sv | 49 ++++
 tb/tb_risc_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: opcode and phase encodings shared by the VeriRISC sequencer files.
package risc_pkg;
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;
  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;
  function automatic logic is_aluop(input logic [2:0] op);
    return op == ADD || op == AND || op == XOR || op == LDA;
  endfunction
endpackage

// File: rtl/risc_phase_counter.sv
// risc_phase_counter: 3-bit wrapping phase counter with enable and freeze.
module risc_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_freeze,
  output logic [2:0] o_phase
);
  logic [2:0] r_phase;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_phase <= 3'd0;
    else if (i_en && !i_freeze) r_phase <= r_phase + 3'd1;
  end
  assign o_phase = r_phase;
endmodule

// File: rtl/risc_sequencer.sv
// risc_sequencer: VeriRISC phase controller decoding opcode into per-phase strobes.
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int OPC_WIDTH   = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [OPC_WIDTH-1:0] opcode,
  input  logic                 zero,
  output logic [2:0]           phase,
  output logic                 sel,
  output logic                 rd,
  output logic                 ld_ir,
  output logic                 halt,
  output logic                 inc_pc,
  output logic                 ld_ac,
  output logic                 ld_pc,
  output logic                 wr,
  output logic                 data_e
);
  logic r_halted;
  logic w_alu, w_run;
  risc_phase_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_en     (enable),
    .i_freeze (r_halted),
    .o_phase  (phase)
  );
  // The edge leaving OP_ADDR on HLT moves phase to 5 and then freezes it there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_halted <= 1'b0;
    else if (HALT_STICKY && enable && phase == OP_ADDR && opcode == HLT) r_halted <= 1'b1;
  end
  assign w_alu  = is_aluop(opcode);
  assign w_run  = !r_halted;
  assign sel    = phase <= IDLE;
  assign rd     = w_run && ((phase >= INST_FETCH && phase <= IDLE) || (phase >= OP_FETCH && w_alu));
  assign ld_ir  = w_run && (phase == INST_LOAD || phase == IDLE);
  assign halt   = r_halted || (phase == OP_ADDR && opcode == HLT);
  assign inc_pc = w_run && (phase == OP_ADDR || (phase == ALU_OP && opcode == SKZ && zero));
  assign ld_ac  = w_run && phase == STORE && w_alu;
  assign ld_pc  = w_run && phase >= ALU_OP && opcode == JMP;
  assign wr     = w_run && phase == STORE && opcode == STO;
  assign data_e = w_run && phase >= ALU_OP && opcode == STO;
endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer: directed checks of phase sequencing, strobe decode, stall, halt and reset.
module tb_risc_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] opcode = 3'd2;
  logic       zero = 1'b0;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [8:0] outs;
  int vectors = 0;
  int miscompares = 0;
  // Bit order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
  logic [8:0] t_add  [0:7] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h010, 9'h080, 9'h080, 9'h088};
  logic [8:0] t_sto  [0:7] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h010, 9'h000, 9'h001, 9'h003};
  logic [8:0] t_skz1 [0:7] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h010, 9'h000, 9'h010, 9'h000};
  logic [8:0] t_skz0 [0:7] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h010, 9'h000, 9'h000, 9'h000};
  logic [8:0] t_jmp  [0:7] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h010, 9'h000, 9'h004, 9'h004};

  risc_sequencer #(.OPC_WIDTH(3), .HALT_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .opcode(opcode), .zero(zero),
    .phase(phase), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e)
  );
  always #5 clk = ~clk;
  assign outs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [8:0] t [0:7]);
    opcode = op;
    zero = z;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("%s_phase%0d", name, p), {6'd0, phase}, 9'(p));
      chk($sformatf("%s_outs%0d", name, p), outs, t[p]);
      @(negedge clk);
    end
    chk($sformatf("%s_wrap", name), {6'd0, phase}, 9'd0);
  endtask

  initial begin
    #1;
    chk("reset_phase", {6'd0, phase}, 9'd0);
    chk("reset_outs", outs, 9'h100);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    run_instr("add", 3'd2, 1'b0, t_add);
    run_instr("sto", 3'd6, 1'b0, t_sto);
    run_instr("skz_z1", 3'd1, 1'b1, t_skz1);
    run_instr("skz_z0", 3'd1, 1'b0, t_skz0);
    opcode = 3'd7;
    repeat (6) @(negedge clk);
    chk("jmp_p6_phase", {6'd0, phase}, 9'd6);
    chk("jmp_p6_outs", outs, t_jmp[6]);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("jmp_stall%0d_phase", i), {6'd0, phase}, 9'd6);
      chk($sformatf("jmp_stall%0d_outs", i), outs, t_jmp[6]);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("jmp_p7_phase", {6'd0, phase}, 9'd7);
    chk("jmp_p7_outs", outs, t_jmp[7]);
    @(negedge clk);
    opcode = 3'd2;
    repeat (6) @(negedge clk);
    chk("midrst_pre_phase", {6'd0, phase}, 9'd6);
    rst = 1'b0;
    #1;
    chk("midrst_phase", {6'd0, phase}, 9'd0);
    chk("midrst_outs", outs, 9'h100);
    @(negedge clk);
    rst = 1'b1;
    opcode = 3'd0;
    repeat (4) @(negedge clk);
    chk("hlt_p4_phase", {6'd0, phase}, 9'd4);
    chk("hlt_p4_outs", outs, 9'h030);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("hlt_stall_phase", {6'd0, phase}, 9'd4);
    chk("hlt_stall_outs", outs, 9'h030);
    enable = 1'b1;
    @(negedge clk);
    chk("hlt_p5_phase", {6'd0, phase}, 9'd5);
    chk("hlt_p5_outs", outs, 9'h020);
    opcode = 3'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("halted%0d_phase", i), {6'd0, phase}, 9'd5);
      chk($sformatf("halted%0d_outs", i), outs, 9'h020);
    end
    rst = 1'b0;
    #1;
    chk("hltrst_phase", {6'd0, phase}, 9'd0);
    chk("hltrst_outs", outs, 9'h100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_phase", {6'd0, phase}, 9'd1);
    chk("post_rst_outs", outs, 9'h180);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
